clkdiv_sched: RTL and testbench

Programmable multi-channel clock-enable divider controller. It sequences NCH independent divider channels from one system clock and produces per-channel single-cycle tick enables and square-wave divided outputs. Channels can be reconfigured at run time through a valid/ready config port, and downstream logic consumes the ticks instead of rippled clocks. Any channel k>0 can optionally cascade off channel k-1's tick, giving a fully synchronous equivalent of a ripple divider chain.

---
 rtl/clkdiv_pkg.sv | 23 ++
 rtl/clkdiv_sched_if.sv | 24 ++
 rtl/clkdiv_chan.sv | 106 ++++++++++
 rtl/clkdiv_sched.sv | 62 ++++++
 tb/tb_clkdiv_sched.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clkdiv_sched multi-channel clock-enable divider.
package clkdiv_pkg;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    localparam int CW_MAX  = 16;
    localparam int DIV_MIN = 2;

    typedef struct packed {
        logic [CW_MAX-1:0] pdiv;
        logic              pen;
        logic              pcasc;
    } pend_t;

    // Ratios below DIV_MIN have no meaningful square wave, so they are raised to DIV_MIN.
    function automatic logic [CW_MAX-1:0] clamp_div(input logic [CW_MAX-1:0] d);
        return (d < CW_MAX'(DIV_MIN)) ? CW_MAX'(DIV_MIN) : d;
    endfunction

endpackage

// File: rtl/clkdiv_sched_if.sv
// Run-time configuration port of clkdiv_sched: one valid/ready request per channel write.
interface clkdiv_sched_if #(
    parameter int NCH = 2,
    parameter int CW  = 8
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_en;
    logic           cfg_casc;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_en, cfg_casc,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_en, cfg_casc,
        output cfg_ready
    );
endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel: period counter, IDLE/RUN state, and a single-entry pending
// config slot that is only applied at the end of a period.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int CW      = 8,
    parameter bit CASC_OK = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          acc_i,
    input  logic [CW-1:0] div_i,
    input  logic          en_i,
    input  logic          casc_i,
    input  logic          up_tick_i,
    output logic          pv_o,
    output logic          tick_o,
    output logic          div_o,
    output logic          active_o
);
    ch_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] div_q, div_d;
    logic          casc_q, casc_d;
    logic          pv_q, pv_d;
    pend_t         pend_q, pend_d;

    logic          adv;
    logic          last;
    logic [CW:0]   half;
    logic [CW-1:0] new_div;
    logic          new_casc;

    assign new_div  = CW'(clamp_div(CW_MAX'(div_i)));
    assign new_casc = CASC_OK & casc_i;

    assign adv  = casc_q ? up_tick_i : 1'b1;
    assign last = (cnt_q == div_q - CW'(1));
    // ceil(D/2) computed one bit wider so D = 2^CW-1 does not overflow.
    assign half = ({1'b0, div_q} + (CW+1)'(1)) >> 1;

    assign tick_o   = (state_q == CH_RUN) && adv && last;
    assign div_o    = (state_q == CH_RUN) && ({1'b0, cnt_q} < half);
    assign active_o = (state_q == CH_RUN);
    assign pv_o     = pv_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        casc_d  = casc_q;
        pv_d    = pv_q;
        pend_d  = pend_q;
        case (state_q)
            CH_IDLE: begin
                if (acc_i && en_i) begin
                    state_d = CH_RUN;
                    cnt_d   = '0;
                    div_d   = new_div;
                    casc_d  = new_casc;
                end
            end
            CH_RUN: begin
                if (adv && last) begin
                    cnt_d = '0;
                    if (pv_q) begin
                        pv_d = 1'b0;
                        if (pend_q.pen) begin
                            div_d  = CW'(pend_q.pdiv);
                            casc_d = pend_q.pcasc;
                        end else begin
                            state_d = CH_IDLE;
                        end
                    end
                end else if (adv) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Acceptance only happens with pv_q low, so a same-cycle wrap leaves it for the next period.
                if (acc_i) begin
                    pv_d   = 1'b1;
                    pend_d = '{pdiv: CW_MAX'(new_div), pen: en_i, pcasc: new_casc};
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            div_q   <= CW'(DIV_MIN);
            casc_q  <= 1'b0;
            pv_q    <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            casc_q  <= casc_d;
            pv_q    <= pv_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: rtl/clkdiv_sched.sv
// Multi-channel clock-enable divider: NCH channels with optional tick cascading
// and a shared valid/ready configuration port.
module clkdiv_sched
    import clkdiv_pkg::*;
#(
    parameter int NCH = 2,
    parameter int CW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    clkdiv_sched_if.slave   cfg,
    output logic [NCH-1:0]  tick_o,
    output logic [NCH-1:0]  div_o,
    output logic [NCH-1:0]  active_o
);
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NSLOT = 1 << CHW;

    logic [NCH-1:0]   pv;
    logic [NSLOT-1:0] free;
    logic             accept;

    // Channel numbers with no channel behind them are always free, so such writes are swallowed.
    always_comb begin
        free          = '1;
        free[NCH-1:0] = ~pv;
    end

    assign cfg.cfg_ready = free[cfg.cfg_ch];
    assign accept        = cfg.cfg_valid & cfg.cfg_ready;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic tick_w;
        logic up_tick;

        if (k == 0) begin : g_first
            assign up_tick = 1'b0;
        end else begin : g_rest
            assign up_tick = g_ch[k-1].tick_w;
        end

        clkdiv_chan #(
            .CW      (CW),
            .CASC_OK (k > 0)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .acc_i     (accept && (cfg.cfg_ch == CHW'(k))),
            .div_i     (cfg.cfg_div),
            .en_i      (cfg.cfg_en),
            .casc_i    (cfg.cfg_casc),
            .up_tick_i (up_tick),
            .pv_o      (pv[k]),
            .tick_o    (tick_w),
            .div_o     (div_o[k]),
            .active_o  (active_o[k])
        );

        assign tick_o[k] = tick_w;
    end

endmodule

// File: tb/tb_clkdiv_sched.sv
// Directed, table-driven bench for clkdiv_sched with three channels.
module tb_clkdiv_sched;
    localparam int NCH = 3;
    localparam int CW  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clkdiv_sched_if #(.NCH(NCH), .CW(CW)) cfg_if ();

    logic [NCH-1:0] tick_o;
    logic [NCH-1:0] div_o;
    logic [NCH-1:0] active_o;

    clkdiv_sched #(.NCH(NCH), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg      (cfg_if.slave),
        .tick_o   (tick_o),
        .div_o    (div_o),
        .active_o (active_o)
    );

    typedef struct packed {
        logic       r;
        logic       v;
        logic [1:0] ch;
        logic [7:0] dv;
        logic       en;
        logic       cs;
        logic       rdy;
        logic [2:0] t;
        logic [2:0] d;
        logic [2:0] a;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] ch,
                                input logic [7:0] dv, input logic en, input logic cs,
                                input logic rdy, input logic [2:0] t, input logic [2:0] d,
                                input logic [2:0] a);
        return '{r: r, v: v, ch: ch, dv: dv, en: en, cs: cs, rdy: rdy, t: t, d: d, a: a};
    endfunction

    function automatic vec_t idle(input logic rdy, input logic [2:0] t, input logic [2:0] d,
                                  input logic [2:0] a);
        return mk(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, rdy, t, d, a);
    endfunction

    task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] dv,
                         input logic en, input logic cs);
        cfg_if.cfg_valid = v;
        cfg_if.cfg_ch    = ch;
        cfg_if.cfg_div   = dv;
        cfg_if.cfg_en    = en;
        cfg_if.cfg_casc  = cs;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);

        // Reset, then ch0 D=4: 1,1,0,0 with tick on cnt=3.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3'b000, 3'b000, 3'b000));
        vecs.push_back(mk(0, 1, 0, 4, 1, 0, 1, 3'b000, 3'b000, 3'b000));
        vecs.push_back(idle(1, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(1, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(1, 3'b000, 3'b000, 3'b001));
        vecs.push_back(idle(1, 3'b001, 3'b000, 3'b001));
        vecs.push_back(idle(1, 3'b000, 3'b001, 3'b001));
        // Write D=6 at cnt=1; second write stalls; current period stays 4.
        vecs.push_back(mk(0, 1, 0, 6, 1, 0, 1, 3'b000, 3'b001, 3'b001));
        vecs.push_back(mk(0, 1, 0, 3, 1, 0, 0, 3'b000, 3'b000, 3'b001));
        vecs.push_back(idle(0, 3'b001, 3'b000, 3'b001));
        vecs.push_back(idle(1, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(1, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(1, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(1, 3'b000, 3'b000, 3'b001));
        vecs.push_back(idle(1, 3'b000, 3'b000, 3'b001));
        // Write D=2 on the wrap cycle: next period is still 6.
        vecs.push_back(mk(0, 1, 0, 2, 1, 0, 1, 3'b001, 3'b000, 3'b001));
        vecs.push_back(idle(0, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(0, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(0, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(0, 3'b000, 3'b000, 3'b001));
        vecs.push_back(idle(0, 3'b000, 3'b000, 3'b001));
        vecs.push_back(idle(0, 3'b001, 3'b000, 3'b001));
        vecs.push_back(mk(0, 1, 0, 5, 1, 0, 1, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(0, 3'b001, 3'b000, 3'b001));
        // D=5 running, stop request: one more full period then IDLE.
        vecs.push_back(mk(0, 1, 0, 5, 0, 0, 1, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(0, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(0, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(0, 3'b000, 3'b000, 3'b001));
        vecs.push_back(idle(0, 3'b001, 3'b000, 3'b001));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 1, 3'b000, 3'b000, 3'b000));
        vecs.push_back(idle(1, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(1, 3'b001, 3'b000, 3'b001));
        vecs.push_back(mk(0, 1, 0, 5, 1, 0, 1, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(0, 3'b001, 3'b000, 3'b001));
        // Pending write, then reset at cnt=2 discards everything.
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(0, 3'b000, 3'b001, 3'b001));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3'b000, 3'b000, 3'b000));
        vecs.push_back(idle(1, 3'b000, 3'b000, 3'b000));
        vecs.push_back(idle(1, 3'b000, 3'b000, 3'b000));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, 3'b000, 3'b000, 3'b000));
        // Write to nonexistent channel 3: ready and dropped.
        vecs.push_back(mk(0, 1, 3, 9, 1, 0, 1, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(1, 3'b001, 3'b000, 3'b001));
        vecs.push_back(idle(1, 3'b000, 3'b001, 3'b001));
        // Cascade: ch0 D=3, ch1 D=2 casc.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3'b000, 3'b000, 3'b000));
        vecs.push_back(mk(0, 1, 0, 3, 1, 0, 1, 3'b000, 3'b000, 3'b000));
        vecs.push_back(mk(0, 1, 1, 2, 1, 1, 1, 3'b000, 3'b001, 3'b001));
        vecs.push_back(idle(1, 3'b000, 3'b011, 3'b011));
        vecs.push_back(idle(1, 3'b001, 3'b010, 3'b011));
        vecs.push_back(idle(1, 3'b000, 3'b001, 3'b011));
        vecs.push_back(idle(1, 3'b000, 3'b001, 3'b011));
        vecs.push_back(idle(1, 3'b011, 3'b000, 3'b011));
        vecs.push_back(idle(1, 3'b000, 3'b011, 3'b011));
        vecs.push_back(idle(1, 3'b000, 3'b011, 3'b011));
        vecs.push_back(idle(1, 3'b001, 3'b010, 3'b011));
        vecs.push_back(idle(1, 3'b000, 3'b001, 3'b011));
        vecs.push_back(idle(1, 3'b000, 3'b001, 3'b011));
        vecs.push_back(idle(1, 3'b011, 3'b000, 3'b011));
        // Stop ch0: ch1 then holds cnt with no ticks.
        vecs.push_back(mk(0, 1, 0, 3, 0, 0, 1, 3'b000, 3'b011, 3'b011));
        vecs.push_back(idle(0, 3'b000, 3'b011, 3'b011));
        vecs.push_back(idle(0, 3'b001, 3'b010, 3'b011));
        vecs.push_back(idle(1, 3'b000, 3'b000, 3'b010));
        vecs.push_back(idle(1, 3'b000, 3'b000, 3'b010));
        vecs.push_back(idle(1, 3'b000, 3'b000, 3'b010));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].r;
            drive(vecs[i].v, vecs[i].ch, vecs[i].dv, vecs[i].en, vecs[i].cs);
            #1;
            chk("cfg_ready", i, 8'(cfg_if.cfg_ready), 8'(vecs[i].rdy));
            chk("tick_o",    i, 8'(tick_o),           8'(vecs[i].t));
            chk("div_o",     i, 8'(div_o),            8'(vecs[i].d));
            chk("active_o",  i, 8'(active_o),         8'(vecs[i].a));
        end

        // Three-deep chain: ch2 cascades off stalled ch1, then ch0 restarts.
        @(negedge clk);
        drive(1'b1, 2'd2, 8'd2, 1'b1, 1'b1);
        #1 chk("seq_ready_ch2", 0, 8'(cfg_if.cfg_ready), 8'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
            #1;
            chk("seq_hold_tick",   c, 8'(tick_o),   8'b000);
            chk("seq_hold_div",    c, 8'(div_o),    8'b100);
            chk("seq_hold_active", c, 8'(active_o), 8'b110);
        end
        @(negedge clk);
        drive(1'b1, 2'd0, 8'd2, 1'b1, 1'b0);
        #1 chk("seq_ready_ch0", 0, 8'(cfg_if.cfg_ready), 8'd1);
        seen = 1'b0;
        n    = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
            #1;
            if (tick_o[2]) begin
                seen = 1'b1;
                n    = c;
                chk("seq_chain_tick", c, 8'(tick_o), 8'b111);
            end
        end
        chk("seq_chain_seen",    0, 8'(seen), 8'd1);
        chk("seq_chain_latency", 0, 8'(n),    8'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
